// File: rtl/ground_pixel_writer.sv
// ground_pixel_writer: depth-tested pixel writer for the ground-sample stream.
// It owns the per-frame clear of the depth and frame RAMs, then runs a 3-stage
// read / wait / compare-and-write pipeline with a two-deep write bypass.
//
// Handshake: 'en' is a qualifier with no back-pressure. A sample presented with
// en=1 in a cycle where busy=0 and frame_start=0 is either accepted (in range)
// or dropped (out of range). While busy=1 every en=1 sample is dropped. The
// pipeline never stalls.
module ground_pixel_writer #(
  parameter int WIDTH     = 321,
  parameter int HEIGHT    = 321,
  parameter int MAX_DEPTH = 511,
  parameter int BG_COLOR  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        en,
  input  logic [9:0]  in_x,
  input  logic [9:0]  in_y,
  input  logic [9:0]  in_z,
  input  logic [9:0]  in_p,
  output logic [16:0] depth_rd_addr,
  input  logic [9:0]  depth_rd_data,
  output logic [16:0] wr_addr,
  output logic [9:0]  depth_wr_data,
  output logic        depth_we,
  output logic [9:0]  fb_wr_data,
  output logic        fb_we,
  output logic        busy,
  output logic [16:0] drawn_cnt,
  output logic [16:0] drop_cnt
);

  localparam logic [16:0] LP_LAST = 17'(WIDTH * HEIGHT - 1);
  localparam logic [16:0] LP_W    = 17'(WIDTH);
  localparam logic [16:0] LP_H    = 17'(HEIGHT);
  localparam logic [9:0]  LP_MAXD = 10'(MAX_DEPTH);
  localparam logic [9:0]  LP_BG   = 10'(BG_COLOR);
  localparam logic [16:0] LP_SAT  = 17'h1ffff;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t      r_state, w_state_nxt;
  logic [16:0] r_clr_addr, w_clr_addr_nxt;
  logic        w_clear_we;

  logic        r_busy;
  logic        w_in_range, w_accept, w_drop;
  logic [16:0] w_addr;

  logic        r_s1_valid, r_s2_valid;
  logic [16:0] r_s1_addr, r_s2_addr;
  logic [9:0]  r_s1_z, r_s1_p, r_s2_z, r_s2_p;

  logic        r_we, r_prev_we;
  logic [16:0] r_wr_addr, r_prev_addr;
  logic [9:0]  r_wr_data, r_prev_data, r_fb_data;
  logic [9:0]  w_eff_depth;
  logic        w_commit;

  logic [16:0] r_drawn, r_drop;

  // State register and clear-sweep address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  // Next state: frame_start always restarts the sweep; CLEAR walks every address once.
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_clear_we     = 1'b0;
    if (frame_start) begin
      w_state_nxt    = ST_CLEAR;
      w_clr_addr_nxt = '0;
    end else if (r_state == ST_CLEAR) begin
      w_clear_we = 1'b1;
      if (r_clr_addr == LP_LAST) begin
        w_state_nxt    = ST_RUN;
        w_clr_addr_nxt = '0;
      end else begin
        w_clr_addr_nxt = r_clr_addr + 17'd1;
      end
    end
  end

  // Input qualification: negative coordinates show up as a set sign bit.
  always_comb begin
    w_in_range = !in_x[9] && !in_y[9] && ({7'd0, in_x} < LP_W) && ({7'd0, in_y} < LP_H);
    w_addr     = {7'd0, in_y} * LP_W + {7'd0, in_x};
    w_accept   = en && !frame_start && !r_busy && w_in_range;
    w_drop     = en && !frame_start && (r_busy || !w_in_range);
  end

  // Effective stored depth: newest in-flight write to the same pixel wins over RAM data,
  // because the RAM returns pre-write contents for the two most recent writes.
  always_comb begin
    w_eff_depth = depth_rd_data;
    if (r_we && (r_wr_addr == r_s2_addr)) begin
      w_eff_depth = r_wr_data;
    end else if (r_prev_we && (r_prev_addr == r_s2_addr)) begin
      w_eff_depth = r_prev_data;
    end
    w_commit = r_s2_valid && ($signed(r_s2_z) < $signed(w_eff_depth));
  end

  // S1 (address issue) and S2 (RAM latency); frame_start kills both stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_z     <= '0;
      r_s1_p     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_addr  <= '0;
      r_s2_z     <= '0;
      r_s2_p     <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_addr <= w_addr;
        r_s1_z    <= in_z;
        r_s1_p    <= in_p;
      end
      r_s2_valid <= r_s1_valid && !frame_start;
      r_s2_addr  <= r_s1_addr;
      r_s2_z     <= r_s1_z;
      r_s2_p     <= r_s1_p;
    end
  end

  // S3 write port: clear writes or depth-test winners; previous write kept for the bypass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we        <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_fb_data   <= '0;
      r_prev_we   <= 1'b0;
      r_prev_addr <= '0;
      r_prev_data <= '0;
    end else begin
      r_prev_we   <= r_we;
      r_prev_addr <= r_wr_addr;
      r_prev_data <= r_wr_data;
      if (frame_start) begin
        r_we <= 1'b0;
      end else if (w_clear_we) begin
        r_we      <= 1'b1;
        r_wr_addr <= r_clr_addr;
        r_wr_data <= LP_MAXD;
        r_fb_data <= LP_BG;
      end else if (w_commit) begin
        r_we      <= 1'b1;
        r_wr_addr <= r_s2_addr;
        r_wr_data <= r_s2_z;
        r_fb_data <= r_s2_p;
      end else begin
        r_we <= 1'b0;
      end
    end
  end

  // Busy stays high through the cycle showing the last clear write; saturating counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= 1'b1;
      r_drawn <= '0;
      r_drop  <= '0;
    end else begin
      r_busy <= frame_start || (r_state == ST_CLEAR);
      if (frame_start) begin
        r_drawn <= '0;
        r_drop  <= '0;
      end else begin
        if (w_commit && (r_drawn != LP_SAT)) r_drawn <= r_drawn + 17'd1;
        if (w_drop && (r_drop != LP_SAT))    r_drop  <= r_drop + 17'd1;
      end
    end
  end

  assign depth_rd_addr = r_s1_addr;
  assign wr_addr       = r_wr_addr;
  assign depth_wr_data = r_wr_data;
  assign fb_wr_data    = r_fb_data;
  assign depth_we      = r_we;
  assign fb_we         = r_we;
  assign busy          = r_busy;
  assign drawn_cnt     = r_drawn;
  assign drop_cnt      = r_drop;

endmodule

// File: tb/tb_ground_pixel_writer.sv
// Bench for ground_pixel_writer with a reduced frame so a full clear is short.
module tb_ground_pixel_writer;

  localparam int W    = 21;
  localparam int H    = 10;
  localparam int N    = W * H;
  localparam int MAXD = 511;
  localparam int BG   = 0;
  localparam int SAT  = 131071;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        frame_start = 1'b0;
  logic        en = 1'b0;
  logic [9:0]  in_x = '0, in_y = '0, in_z = '0, in_p = '0;
  logic [16:0] depth_rd_addr, wr_addr, drawn_cnt, drop_cnt;
  logic [9:0]  depth_rd_data, depth_wr_data, fb_wr_data;
  logic        depth_we, fb_we, busy;

  ground_pixel_writer #(.WIDTH(W), .HEIGHT(H), .MAX_DEPTH(MAXD), .BG_COLOR(BG)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .en(en),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_p(in_p),
    .depth_rd_addr(depth_rd_addr), .depth_rd_data(depth_rd_data),
    .wr_addr(wr_addr), .depth_wr_data(depth_wr_data), .depth_we(depth_we),
    .fb_wr_data(fb_wr_data), .fb_we(fb_we), .busy(busy),
    .drawn_cnt(drawn_cnt), .drop_cnt(drop_cnt)
  );

  // ---------------- RAMs (read-before-write, 1-cycle read latency) ----------------
  logic [9:0] depth_mem [N];
  logic [9:0] fb_mem [N];
  initial begin
    for (int i = 0; i < N; i++) begin
      depth_mem[i] = '0;
      fb_mem[i]    = '0;
    end
  end
  always @(posedge clk) begin
    depth_rd_data <= (int'(depth_rd_addr) < N) ? depth_mem[depth_rd_addr] : 10'd0;
    if (depth_we && int'(wr_addr) < N) depth_mem[wr_addr] <= depth_wr_data;
    if (fb_we && int'(wr_addr) < N)    fb_mem[wr_addr]    <= fb_wr_data;
  end

  // ---------------- scoreboard bookkeeping ----------------
  int errs = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int n_clear = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      if (errs <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Samples are resolved in arrival order against a per-pixel depth array; the
  // result appears on the write port two edges after acceptance.
  typedef struct { int cyc; int addr; int z; int p; } pend_t;
  pend_t pend[$];
  int    ref_depth [N];
  int    cyc = 0;
  bit    m_clearing = 1'b1;
  int    m_pos = 0;
  bit    m_rst_vis = 1'b1;

  // Expected values for the cycle following each edge.
  logic        exp_we = 1'b0;
  logic [16:0] exp_addr = '0;
  logic [9:0]  exp_dz = '0, exp_p = '0;
  logic        exp_busy = 1'b1;
  int          exp_drawn = 0, exp_drop = 0;
  logic        exp_rd_chk = 1'b0;
  logic [16:0] exp_rd_addr = '0;

  initial for (int i = 0; i < N; i++) ref_depth[i] = 0;

  always @(posedge clk) begin
    int  xs, ys, zs;
    bit  was_busy;
    pend_t e;
    exp_we     = 1'b0;
    exp_rd_chk = 1'b0;
    m_rst_vis  = 1'b0;
    if (rst) begin
      pend.delete();
      m_clearing = 1'b1; m_pos = 0; exp_busy = 1'b1;
      exp_drawn = 0; exp_drop = 0; m_rst_vis = 1'b1;
    end else if (frame_start) begin
      pend.delete();
      m_clearing = 1'b1; m_pos = 0; exp_busy = 1'b1;
      exp_drawn = 0; exp_drop = 0;
    end else begin
      was_busy = exp_busy;
      if (m_clearing) begin
        exp_we = 1'b1; exp_addr = 17'(m_pos); exp_dz = 10'(MAXD); exp_p = 10'(BG);
        ref_depth[m_pos] = MAXD;
        m_pos++;
        if (m_pos == N) m_clearing = 1'b0;
        exp_busy = 1'b1;
      end else begin
        exp_busy = 1'b0;
        if (pend.size() > 0 && pend[0].cyc == cyc - 2) begin
          e = pend.pop_front();
          if (e.z < ref_depth[e.addr]) begin
            exp_we = 1'b1; exp_addr = 17'(e.addr); exp_dz = 10'(e.z); exp_p = 10'(e.p);
            ref_depth[e.addr] = e.z;
            if (exp_drawn < SAT) exp_drawn++;
          end
        end
      end
      if (en) begin
        xs = int'($signed(in_x));
        ys = int'($signed(in_y));
        zs = int'($signed(in_z));
        if (was_busy || xs < 0 || xs >= W || ys < 0 || ys >= H) begin
          if (exp_drop < SAT) exp_drop++;
        end else begin
          pend.push_back('{cyc: cyc, addr: ys * W + xs, z: zs, p: int'(in_p)});
          exp_rd_chk  = 1'b1;
          exp_rd_addr = 17'(ys * W + xs);
        end
      end
    end
    cyc++;
  end

  // ---------------- compare process (every cycle, on the falling edge) ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("depth_we", depth_we, exp_we);
      check("fb_we", fb_we, exp_we);
      if (exp_we) begin
        check("wr_addr", wr_addr, exp_addr);
        check("depth_wr_data", depth_wr_data, exp_dz);
        check("fb_wr_data", fb_wr_data, exp_p);
      end
      check("busy", busy, exp_busy);
      check("drawn_cnt", drawn_cnt, exp_drawn);
      check("drop_cnt", drop_cnt, exp_drop);
      if (exp_rd_chk) check("depth_rd_addr", depth_rd_addr, exp_rd_addr);
      if (m_rst_vis) begin
        check("rst_wr_addr", wr_addr, 0);
        check("rst_rd_addr", depth_rd_addr, 0);
      end
      if (depth_we && busy) n_clear++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit fs, input bit e, input int x, input int y, input int z, input int p);
    frame_start = fs;
    en   = e;
    in_x = 10'(x);
    in_y = 10'(y);
    in_z = 10'(z);
    in_p = 10'(p);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic wait_clear_done(input int budget);
    int k;
    frame_start = 1'b0;
    en = 1'b0;
    k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("clear_timeout", 1, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy_lit", busy, 1);
    check("rst_we_lit", depth_we, 0);
    check("rst_drawn_lit", drawn_cnt, 0);
    idle(2);
    rst = 1'b0;
    n_clear = 0;
    wait_clear_done(N + 20);
    check("clear_count_lit", n_clear, N);
    check("clear_last_lit", depth_mem[N-1], MAXD);
    check("clear_cnts_lit", drawn_cnt + drop_cnt, 0);

    // First sample: pixel (10,2) -> address 2*21+10 = 52, write in cycle 3.
    drive(1'b0, 1'b1, 10, 2, 100, 7);
    idle(2);
    check("s1_we_lit", depth_we, 1);
    check("s1_addr_lit", wr_addr, 52);
    check("s1_dz_lit", depth_wr_data, 100);
    check("s1_p_lit", fb_wr_data, 7);
    check("s1_drawn_lit", drawn_cnt, 1);

    // Farther, nearer, then equal depth on the same pixel.
    drive(1'b0, 1'b1, 10, 2, 150, 9);
    drive(1'b0, 1'b1, 10, 2, 50, 3);
    drive(1'b0, 1'b1, 10, 2, 50, 5);
    idle(4);
    check("seq_drawn_lit", drawn_cnt, 2);
    check("seq_depth_lit", depth_mem[52], 50);
    check("seq_fb_lit", fb_mem[52], 3);

    // Back-to-back hazard on pixel (3,4) -> address 87.
    drive(1'b0, 1'b1, 3, 4, 200, 1);
    drive(1'b0, 1'b1, 3, 4, 100, 2);
    drive(1'b0, 1'b1, 3, 4, 150, 3);
    idle(4);
    check("byp_drawn_lit", drawn_cnt, 4);
    check("byp_depth_lit", depth_mem[87], 100);
    check("byp_fb_lit", fb_mem[87], 2);

    // Out-of-range drops, then the last valid pixel and one past the row end.
    drive(1'b0, 1'b1, -5, 0, 10, 1);
    drive(1'b0, 1'b1, 321, 0, 10, 1);
    drive(1'b0, 1'b1, 0, 400, 10, 1);
    idle(1);
    check("drop3_lit", drop_cnt, 3);
    drive(1'b0, 1'b1, W - 1, H - 1, 10, 4);
    drive(1'b0, 1'b1, W, 0, 10, 4);
    idle(4);
    check("drop4_lit", drop_cnt, 4);
    check("edge_depth_lit", depth_mem[N-1], 10);
    check("edge_drawn_lit", drawn_cnt, 5);

    // Random traffic concentrated on a few pixels to stress the bypass.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 7)) - 2,
            int'($urandom_range(0, 4)) - 1,
            int'($urandom_range(0, 1023)) - 512,
            int'($urandom_range(0, 1023)));
    end
    wait_clear_done(N + 20);
    idle(3);

    // Three accepted samples, frame_start lands while they are in flight.
    drive(1'b0, 1'b1, 1, 1, -100, 11);
    drive(1'b0, 1'b1, 2, 1, -100, 12);
    drive(1'b1, 1'b1, 3, 1, -100, 13);
    frame_start = 1'b0;
    en = 1'b0;
    check("kill_we_lit", depth_we, 0);
    check("kill_busy_lit", busy, 1);
    check("kill_drawn_lit", drawn_cnt, 0);
    idle(1);
    check("kill_restart_we_lit", depth_we, 1);
    check("kill_restart_addr_lit", wr_addr, 0);

    // Restart while clearing; a sample during clear is dropped.
    idle(30);
    drive(1'b0, 1'b1, 5, 5, 1, 1);
    drive(1'b1, 1'b0, 0, 0, 0, 0);
    idle(1);
    check("restart_addr_lit", wr_addr, 0);
    check("restart_drop_lit", drop_cnt, 0);
    wait_clear_done(N + 20);

    for (int i = 0; i < 150; i++) begin
      drive(1'b0, ($urandom_range(0, 3) != 0),
            int'($urandom_range(0, W + 2)) - 1,
            int'($urandom_range(0, H + 1)) - 1,
            int'($urandom_range(0, 1023)) - 512,
            int'($urandom_range(0, 1023)));
    end
    idle(5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ground_pixel_writer.md
# ground_pixel_writer

Downstream consumer of the validated ground-sample stream (`en`, x, y, z, p). It resolves visibility per screen pixel with a depth buffer and writes surviving colour values into the frame buffer. It owns the per-frame clear of both buffers and a 3-stage read-compare-write pipeline with hazard bypass. It sits between ground-sample validation and the dual-port depth/frame RAMs.

## Interface
- `WIDTH`, 321: pixels per row; valid x is 0..WIDTH-1.
- `HEIGHT`, 321: rows; valid y is 0..HEIGHT-1.
- `MAX_DEPTH`, 511: depth written on clear (farthest).
- `BG_COLOR`, 0: colour written on clear.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `frame_start`  in  1  one-cycle pulse; starts buffer clear.
- `en`  in  1  sample valid.
- `in_x`, `in_y`, `in_z`, `in_p`  in  10 each  signed sample coordinates, depth and colour.
- `depth_rd_addr`  out  17  depth RAM read address (registered).
- `depth_rd_data`  in  10  signed; valid the cycle after the address.
- `wr_addr`  out  17  shared write address for depth and frame RAM.
- `depth_wr_data`  out  10  depth write data.
- `depth_we`  out  1  depth write enable.
- `fb_wr_data`  out  10  frame buffer write data.
- `fb_we`  out  1  frame buffer write enable.
- `busy`  out  1  high while clearing.
- `drawn_cnt`  out  17  pixels written this frame (saturating).
- `drop_cnt`  out  17  samples discarded this frame (saturating).

## Operation
- Address is y*WIDTH + x, unsigned, 17 bits.
- **States:**
  - CLEAR: counter walks addresses 0..WIDTH*HEIGHT-1, one per cycle.
    - Each cycle: `depth_we`=`fb_we`=1, writing MAX_DEPTH and BG_COLOR.
    - `busy`=1.
    - After the last address, go to RUN.
  - RUN: samples are processed through the pipeline.
- **Reset:**
  - Enter CLEAR at address 0.
  - All outputs 0 except `busy`=1.
  - Counters and pipeline valids are 0.
- **`frame_start` handling:**
  - In RUN: go to CLEAR and kill all in-flight pipeline entries. Killed entries produce no writes and are not counted.
  - In CLEAR: restart the sweep at 0.
  - In either state: `drawn_cnt` and `drop_cnt` clear to 0.
- **Sample acceptance:**
  - `en`=1 in CLEAR: drop, `drop_cnt`+1.
  - `en`=1 in RUN with x<0, x>=WIDTH, y<0 or y>=HEIGHT: drop, `drop_cnt`+1, no RAM access.
  - `en`=0: ignored.
- **Pipeline:**
  - S1 registers addr/z/p and drives `depth_rd_addr`.
  - S2 holds the entry while RAM data returns.
  - S3 compares z against the effective stored depth. If z < stored (signed, strict), it registers the write: `depth_we`=`fb_we`=1, `depth_wr_data`=z, `fb_wr_data`=p, `drawn_cnt`+1.
  - If z >= stored, no write.
  - Equal depth never overwrites.
- **Effective stored depth:** the first match, in order:
  1. The write currently being issued (previous entry), if its address matches.
  2. The write issued one cycle earlier, if its address matches.
  3. Otherwise `depth_rd_data`.
- The RAM is read-before-write, so these bypasses are mandatory.
- A sample's own read never sees its own write.
- Both counters saturate at 2^17-1.

## Timing
- Sample valid in cycle 0 → `depth_rd_addr` in cycle 1 → RAM data in cycle 2 → `depth_we`/`fb_we` asserted in cycle 3.
- Fixed latency 3. Throughput 1 sample/cycle, no stalls in RUN.
- First clear write in the first cycle after `rst` deasserts.
- Clear takes WIDTH*HEIGHT cycles (103041 at defaults).
- `busy` falls in the cycle after the last clear write.
- A sample with `en`=1 in the cycle `busy` falls is accepted.
- Write enables are single-cycle per entry; no write occurs outside CLEAR or S3 commit.
- Entries in S2/S3 when `frame_start` arrives are discarded the same edge.

## Test plan
- Reset, run to RUN → exactly 103041 clear writes to addresses 0..103040, each with data 511/0; `busy` low after; counters 0.
- Sample (x=10, y=2, z=100, p=7) → in cycle 3: `wr_addr`=652, `depth_wr_data`=100, `fb_wr_data`=7, `drawn_cnt`=1.
- Then same pixel with z=150, p=9 → no write. Then z=50, p=3 → write with 50/3. Then z=50 again → no write.
- Back-to-back same pixel: z=200, 100, 150 on consecutive cycles → writes for 200 and 100 only; final depth 100 (exercises both bypass levels).
- x=-5 (`en`=1), x=321, y=400 → no RAM access, `drop_cnt`=3.
- Three samples accepted, then `frame_start` one cycle later → no write from any of them; `busy`=1; sweep restarts at address 0.
